elevator_request_queue: RTL

ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

---
 rtl/elevator_request_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/elevator_request_queue.sv
// Elevator call queue: latches floor requests into a pending mask, tracks travel
// direction with a small FSM and picks the next floor to serve.
module elevator_request_queue (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_nwr,
    input  logic [2:0] requested_floor,
    input  logic [2:0] current_floor,
    input  logic       arrived,
    output logic [6:0] lamps,
    output logic [1:0] direction,
    output logic [2:0] target_floor,
    output logic       target_valid
);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    logic [6:0] pending_q, pending_d;
    logic [1:0] state_q, state_d;
    logic       floor_ok;
    logic       above, below;
    logic       up_found, down_found;
    logic [2:0] up_idx, down_idx;

    // Floor 7 is not a real floor; it freezes direction and blocks clearing.
    assign floor_ok = (current_floor != 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 7'd0;
            state_q   <= DIR_IDLE;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
        end
    end

    // Clear is applied after set so a same-floor clear wins.
    always_comb begin
        pending_d = pending_q;
        if (!r_nwr && requested_floor != 3'd7) begin
            pending_d[requested_floor] = 1'b1;
        end
        if (arrived && floor_ok) begin
            pending_d[current_floor] = 1'b0;
        end
    end

    always_comb begin
        above      = 1'b0;
        below      = 1'b0;
        up_found   = 1'b0;
        down_found = 1'b0;
        up_idx     = 3'd0;
        down_idx   = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (pending_q[i] && 3'(i) > current_floor) above = 1'b1;
            if (pending_q[i] && 3'(i) < current_floor) begin
                below      = 1'b1;
                down_found = 1'b1;
                down_idx   = 3'(i);
            end
        end
        // Scan downward so the last hit is the lowest floor above the car.
        for (int i = 6; i >= 0; i--) begin
            if (pending_q[i] && 3'(i) > current_floor) begin
                up_found = 1'b1;
                up_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (floor_ok) begin
            case (state_q)
                DIR_UP:   state_d = above ? DIR_UP   : (below ? DIR_DOWN : DIR_IDLE);
                DIR_DOWN: state_d = below ? DIR_DOWN : (above ? DIR_UP   : DIR_IDLE);
                default:  state_d = above ? DIR_UP   : (below ? DIR_DOWN : DIR_IDLE);
            endcase
        end
    end

    always_comb begin
        lamps        = pending_q;
        direction    = state_q;
        target_floor = 3'd0;
        target_valid = 1'b0;
        if (floor_ok) begin
            if (pending_q[current_floor]) begin
                target_floor = current_floor;
                target_valid = 1'b1;
            end else if (state_q == DIR_UP && up_found) begin
                target_floor = up_idx;
                target_valid = 1'b1;
            end else if (state_q == DIR_DOWN && down_found) begin
                target_floor = down_idx;
                target_valid = 1'b1;
            end
        end
    end

endmodule
